// File: rtl/tcp_pkg.sv
// Shared constants, state encoding and checksum helper
// for the TCP transmit path.
package tcp_pkg;

    localparam logic [7:0] PROTO_TCP     = 8'd6;
    localparam int         TCP_HDR_WORDS = 5;
    localparam logic [7:0] OPT_MSS_KIND  = 8'd2;
    localparam logic [7:0] OPT_MSS_LEN   = 8'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SUM,
        ST_HDR,
        ST_DATA
    } state_t;

    // Ones-complement 16-bit add with end-around carry
    function automatic logic [15:0] csum_add(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'b0, s[16]};
    endfunction

endpackage

// File: rtl/tcp_payload_buf.sv
// Payload word buffer: one write port, one async read port,
// auto-incrementing pointers with a synchronous clear.
module tcp_payload_buf #(
    parameter int MAX_WORDS = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    output logic [31:0]       rd_data,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr
);

    logic [31:0] mem [MAX_WORDS];

    // Storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

    // Pointer advance and clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/tcp_encoder.sv
// TCP segment builder: buffers payload, computes checksum,
// streams header + payload as big-endian 32-bit words.
module tcp_encoder
    import tcp_pkg::*;
#(
    parameter int MAX_WORDS = 16,
    parameter int ADDR_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] src_ip,
    input  logic [31:0] dest_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dest_port,
    input  logic [31:0] seq_num,
    input  logic [31:0] ack_num,
    input  logic        f_urg,
    input  logic        f_ack,
    input  logic        f_psh,
    input  logic        f_rst,
    input  logic        f_syn,
    input  logic        f_fin,
    input  logic [15:0] window,
    input  logic [15:0] urg_ptr,
    input  logic        mss_en,
    input  logic [15:0] mss,
    input  logic [15:0] len_data,
    input  logic        start,
    input  logic [31:0] data_tcp,
    input  logic        wr_en,
    output logic [31:0] data,
    output logic        valid,
    output logic [15:0] len_tcp,
    output logic        busy,
    output logic        fin,
    output logic        err
);

    state_t state;

    logic [15:0]     r_src_port;
    logic [15:0]     r_dest_port;
    logic [31:0]     r_seq;
    logic [31:0]     r_ack;
    logic [5:0]      r_flags;
    logic [15:0]     r_window;
    logic [15:0]     r_urg;
    logic [15:0]     r_mss;
    logic [2:0]      r_hw;
    logic [ADDR_W:0] r_nw;
    logic [1:0]      r_rem;
    logic [15:0]     r_len;
    logic [31:0]     acc;
    logic [15:0]     csum;
    logic [2:0]      cnt;

    logic [2:0]        hw_in;
    logic [15:0]       len_in;
    logic [15:0]       len_p3;
    logic [ADDR_W:0]   nw_in;
    logic [ADDR_W:0]   nw_m1;
    logic [5:0]        flags_in;
    logic              too_long;
    logic [31:0]       acc_in;
    logic              wr_last;
    logic [31:0]       wd;
    logic [31:0]       hdr_w;
    logic              buf_clr;
    logic              buf_wr;
    logic              buf_rd;
    logic [31:0]       rd_data;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    assign hw_in    = 3'(TCP_HDR_WORDS) + {2'b0, mss_en};
    assign len_in   = {11'b0, hw_in, 2'b00} + len_data;
    assign len_p3   = len_data + 16'd3;
    assign nw_in    = (ADDR_W+1)'(len_p3 >> 2);
    assign nw_m1    = r_nw - 1'b1;
    assign flags_in = {f_urg, f_ack, f_psh, f_rst, f_syn, f_fin};
    assign too_long = len_data > 16'(4 * MAX_WORDS);
    assign busy     = (state != ST_IDLE);

    assign buf_clr = (state == ST_IDLE) && start && !too_long;
    assign buf_wr  = (state == ST_LOAD) && wr_en;
    assign buf_rd  = (state == ST_DATA) && !fin;
    assign wr_last = buf_wr && ({1'b0, wr_ptr} == nw_m1);

    // Pseudo-header, header and option sum taken at request time
    always_comb begin
        acc_in = {16'b0, src_ip[31:16]} + {16'b0, src_ip[15:0]}
               + {16'b0, dest_ip[31:16]} + {16'b0, dest_ip[15:0]}
               + {24'b0, PROTO_TCP} + {16'b0, len_in}
               + {16'b0, src_port} + {16'b0, dest_port}
               + {16'b0, seq_num[31:16]} + {16'b0, seq_num[15:0]}
               + {16'b0, ack_num[31:16]} + {16'b0, ack_num[15:0]}
               + {16'b0, 1'b0, hw_in, 6'b0, flags_in}
               + {16'b0, window} + {16'b0, urg_ptr};
        if (mss_en)
            acc_in = acc_in + {16'b0, OPT_MSS_KIND, OPT_MSS_LEN}
                   + {16'b0, mss};
    end

    // Zero the bytes past the payload end in the final word
    always_comb begin
        wd = data_tcp;
        if (wr_last) begin
            case (r_rem)
                2'd1:    wd = data_tcp & 32'hFF00_0000;
                2'd2:    wd = data_tcp & 32'hFFFF_0000;
                2'd3:    wd = data_tcp & 32'hFFFF_FF00;
                default: wd = data_tcp;
            endcase
        end
    end

    // Header word selected by the emit counter
    always_comb begin
        case (cnt)
            3'd0:    hdr_w = {r_src_port, r_dest_port};
            3'd1:    hdr_w = r_seq;
            3'd2:    hdr_w = r_ack;
            3'd3:    hdr_w = {1'b0, r_hw, 6'b0, r_flags, r_window};
            3'd4:    hdr_w = {csum, r_urg};
            default: hdr_w = {OPT_MSS_KIND, OPT_MSS_LEN, r_mss};
        endcase
    end

    tcp_payload_buf #(
        .MAX_WORDS (MAX_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (wd),
        .rd_en   (buf_rd),
        .rd_data (rd_data),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr)
    );

    // Segment sequencer with registered stream outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            data        <= '0;
            valid       <= 1'b0;
            fin         <= 1'b0;
            err         <= 1'b0;
            len_tcp     <= '0;
            r_src_port  <= '0;
            r_dest_port <= '0;
            r_seq       <= '0;
            r_ack       <= '0;
            r_flags     <= '0;
            r_window    <= '0;
            r_urg       <= '0;
            r_mss       <= '0;
            r_hw        <= '0;
            r_nw        <= '0;
            r_rem       <= '0;
            r_len       <= '0;
            acc         <= '0;
            csum        <= '0;
            cnt         <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (too_long) begin
                            err <= 1'b1;
                        end else begin
                            r_src_port  <= src_port;
                            r_dest_port <= dest_port;
                            r_seq       <= seq_num;
                            r_ack       <= ack_num;
                            r_flags     <= flags_in;
                            r_window    <= window;
                            r_urg       <= urg_ptr;
                            r_mss       <= mss;
                            r_hw        <= hw_in;
                            r_nw        <= nw_in;
                            r_rem       <= len_data[1:0];
                            r_len       <= len_in;
                            acc         <= acc_in;
                            cnt         <= '0;
                            if (len_data == 16'd0) begin
                                len_tcp <= len_in;
                                state   <= ST_SUM;
                            end else begin
                                state   <= ST_LOAD;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_en) begin
                        acc <= acc + {16'b0, wd[31:16]}
                                   + {16'b0, wd[15:0]};
                        if (wr_last) begin
                            len_tcp <= r_len;
                            state   <= ST_SUM;
                        end
                    end
                end
                ST_SUM: begin
                    csum  <= ~csum_add(acc[15:0], acc[31:16]);
                    data  <= hdr_w;
                    valid <= 1'b1;
                    fin   <= 1'b0;
                    cnt   <= 3'd1;
                    state <= ST_HDR;
                end
                ST_HDR: begin
                    if (fin) begin
                        data  <= '0;
                        valid <= 1'b0;
                        fin   <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        data <= hdr_w;
                        cnt  <= cnt + 3'd1;
                        if (cnt == r_hw - 3'd1) begin
                            if (r_nw == '0)
                                fin <= 1'b1;
                            else
                                state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (fin) begin
                        data  <= '0;
                        valid <= 1'b0;
                        fin   <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        data <= rd_data;
                        if ({1'b0, rd_ptr} == nw_m1)
                            fin <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
